dcc_gamma_ctrl: RTL and testbench

//  Closed-loop controller that computes the TDL tap select (gamma) for the duty-cycle corrector.
//  It consumes phase-detector decisions and runs a binary (SAR) search, then an up/down tracking loop.
//  It drives gamma into the tapped delay line and reports lock and saturation to the system.

---
 rtl/dcc_gamma_ctrl_pkg.sv | 26 ++
 rtl/dcc_gamma_ctrl_settle_timer.sv | 28 ++
 rtl/dcc_gamma_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dcc_gamma_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcc_gamma_ctrl_pkg.sv
// Shared types and constants for the duty-cycle-corrector gamma controller.
package dcc_gamma_ctrl_pkg;

  // Controller states (state | meaning)
  //   ST_IDLE       | waiting for start, gamma held
  //   ST_SAR_SETTLE | SAR trial applied, letting the TDL settle
  //   ST_SAR_WAIT   | waiting for the PD decision on the current SAR bit
  //   ST_TRK_SETTLE | tracking step applied, letting the TDL settle
  //   ST_TRK_WAIT   | accumulating PD decisions towards the filter threshold
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAR_SETTLE = 3'd1,
    ST_SAR_WAIT   = 3'd2,
    ST_TRK_SETTLE = 3'd3,
    ST_TRK_WAIT   = 3'd4
  } state_t;

  // Tracking accumulator width (signed); holds +/-7, enough for any legal threshold.
  localparam int ACC_W = 4;

  // Signed +1 / -1 increment for one PD decision.
  function automatic logic signed [ACC_W-1:0] acc_step(input logic late);
    acc_step = late ? ACC_W'(1) : -ACC_W'(1);
  endfunction

endpackage

// File: rtl/dcc_gamma_ctrl_settle_timer.sv
// Settle down-counter: loaded on entry to a settle state, done when it reaches zero.
module dcc_gamma_ctrl_settle_timer #(
  parameter int CNT_W    = 3,
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise count down to zero while running and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dcc_gamma_ctrl.sv
// Gamma (TDL tap select) controller: SAR acquisition followed by a filtered
// up/down tracking loop with reversal-based lock detection.
module dcc_gamma_ctrl
  import dcc_gamma_ctrl_pkg::*;
#(
  parameter int DELAY_BITS = 5,
  parameter int SETTLE_CYC = 4,
  parameter int FILT_TH    = 3,
  parameter int LOCK_CNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pd_valid,
  input  logic                  pd_late,
  output logic [DELAY_BITS-1:0] gamma,
  output logic                  busy,
  output logic                  locked,
  output logic                  err_sat
);

  localparam int K_W   = (DELAY_BITS > 1) ? $clog2(DELAY_BITS) : 1;
  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam int TMR_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  localparam logic [DELAY_BITS-1:0] GAMMA_MID = {1'b1, {(DELAY_BITS-1){1'b0}}};
  localparam logic [DELAY_BITS-1:0] GAMMA_MAX = '1;
  localparam logic [K_W-1:0]        K_MAX     = K_W'(DELAY_BITS - 1);
  localparam logic [REV_W-1:0]      REV_MAX   = REV_W'(LOCK_CNT);
  localparam logic signed [ACC_W-1:0] TH_P    = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] TH_N    = -TH_P;

  state_t                   state, state_n;
  logic [DELAY_BITS-1:0]    gamma_n;
  logic [K_W-1:0]           k, k_n;
  logic signed [ACC_W-1:0]  acc, acc_n, acc_sum;
  logic [REV_W-1:0]         rev_cnt, rev_n;
  logic                     last_up, last_up_n;
  logic                     have_dir, have_dir_n;
  logic                     locked_n, err_sat_n;
  logic                     step, step_up;
  logic                     timer_load, timer_run, timer_done;

  dcc_gamma_ctrl_settle_timer #(
    .CNT_W   (TMR_W),
    .LOAD_VAL(SETTLE_CYC)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .run  (timer_run),
    .done (timer_done)
  );

  assign timer_run = (state == ST_SAR_SETTLE) || (state == ST_TRK_SETTLE);
  assign busy      = (state != ST_IDLE);

  // State and datapath registers; everything returns to reset values asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gamma    <= GAMMA_MID;
      k        <= K_MAX;
      acc      <= '0;
      rev_cnt  <= '0;
      last_up  <= 1'b0;
      have_dir <= 1'b0;
      locked   <= 1'b0;
      err_sat  <= 1'b0;
    end else begin
      state    <= state_n;
      gamma    <= gamma_n;
      k        <= k_n;
      acc      <= acc_n;
      rev_cnt  <= rev_n;
      last_up  <= last_up_n;
      have_dir <= have_dir_n;
      locked   <= locked_n;
      err_sat  <= err_sat_n;
    end
  end

  // Next-state logic: stop beats start, start restarts from any state, else per-state behaviour.
  always_comb begin
    state_n    = state;
    gamma_n    = gamma;
    k_n        = k;
    acc_n      = acc;
    rev_n      = rev_cnt;
    last_up_n  = last_up;
    have_dir_n = have_dir;
    locked_n   = locked;
    err_sat_n  = err_sat;
    timer_load = 1'b0;
    step       = 1'b0;
    step_up    = 1'b0;
    acc_sum    = acc + acc_step(pd_late);

    if (stop) begin
      state_n = ST_IDLE;
    end else if (start) begin
      state_n    = ST_SAR_SETTLE;
      gamma_n    = GAMMA_MID;
      k_n        = K_MAX;
      acc_n      = '0;
      rev_n      = '0;
      have_dir_n = 1'b0;
      locked_n   = 1'b0;
      err_sat_n  = 1'b0;
      timer_load = 1'b1;
    end else begin
      case (state)
        ST_SAR_SETTLE: begin
          if (timer_done) state_n = ST_SAR_WAIT;
        end
        ST_SAR_WAIT: begin
          if (pd_valid) begin
            gamma_n[k] = pd_late;
            timer_load = 1'b1;
            if (k != '0) begin
              gamma_n[k - 1'b1] = 1'b1;
              k_n               = k - 1'b1;
              state_n           = ST_SAR_SETTLE;
            end else begin
              state_n = ST_TRK_SETTLE;
            end
          end
        end
        ST_TRK_SETTLE: begin
          if (timer_done) state_n = ST_TRK_WAIT;
        end
        ST_TRK_WAIT: begin
          if (pd_valid) begin
            if (acc_sum == TH_P) begin
              step    = 1'b1;
              step_up = 1'b1;
            end else if (acc_sum == TH_N) begin
              step    = 1'b1;
              step_up = 1'b0;
            end else begin
              acc_n = acc_sum;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    // A threshold hit moves gamma one tap (or flags saturation) and updates lock tracking.
    if (step) begin
      acc_n      = '0;
      timer_load = 1'b1;
      state_n    = ST_TRK_SETTLE;
      if (step_up) begin
        if (gamma == GAMMA_MAX) err_sat_n = 1'b1;
        else                    gamma_n   = gamma + 1'b1;
      end else begin
        if (gamma == '0) err_sat_n = 1'b1;
        else             gamma_n   = gamma - 1'b1;
      end
      if (have_dir) begin
        if (step_up != last_up) begin
          if (rev_cnt != REV_MAX) rev_n = rev_cnt + 1'b1;
        end else begin
          rev_n    = '0;
          locked_n = 1'b0;
        end
      end
      if (rev_n == REV_MAX) locked_n = 1'b1;
      last_up_n  = step_up;
      have_dir_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_dcc_gamma_ctrl.sv
// Scoreboard bench for dcc_gamma_ctrl with a behavioural PD and reference model.
module tb_dcc_gamma_ctrl;

  localparam int DB   = 5;
  localparam int SC   = 4;
  localparam int FT   = 3;
  localparam int LC   = 4;
  localparam int GMAX = (1 << DB) - 1;
  localparam int GMID = 1 << (DB - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pd_valid = 1'b0;
  logic          pd_late = 1'b0;
  logic [DB-1:0] gamma;
  logic          busy, locked, err_sat;

  dcc_gamma_ctrl #(
    .DELAY_BITS(DB),
    .SETTLE_CYC(SC),
    .FILT_TH   (FT),
    .LOCK_CNT  (LC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pd_valid(pd_valid),
    .pd_late (pd_late),
    .gamma   (gamma),
    .busy    (busy),
    .locked  (locked),
    .err_sat (err_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int l;
    int e;
    int b;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 SAR, 2 tracking
  int m_phase, m_g, m_k, m_acc, m_rev, m_dir, m_locked, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_g = GMID; m_k = DB - 1; m_acc = 0;
    m_rev = 0; m_dir = 0; m_locked = 0; m_err = 0;
  endfunction

  function automatic void model_start();
    m_phase = 1; m_g = GMID; m_k = DB - 1; m_acc = 0;
    m_rev = 0; m_dir = 0; m_locked = 0; m_err = 0;
  endfunction

  // Applies one accepted PD decision; returns 1 when the controller enters a settle window.
  function automatic bit model_decide(input bit late);
    int dir, ng;
    if (m_phase == 1) begin
      if (!late) m_g = m_g & ~(1 << m_k);
      if (m_k > 0) begin
        m_k = m_k - 1;
        m_g = m_g | (1 << m_k);
      end else begin
        m_phase = 2;
      end
      return 1'b1;
    end
    if (m_phase == 2) begin
      m_acc = m_acc + (late ? 1 : -1);
      if (m_acc == FT || m_acc == -FT) begin
        dir = (m_acc > 0) ? 1 : -1;
        m_acc = 0;
        ng = m_g + dir;
        if (ng < 0 || ng > GMAX) m_err = 1;
        else m_g = ng;
        if (m_dir != 0) begin
          if (dir != m_dir) m_rev = (m_rev < LC) ? m_rev + 1 : LC;
          else begin
            m_rev = 0;
            m_locked = 0;
          end
        end
        if (m_rev == LC) m_locked = 1;
        m_dir = dir;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic exp_t model_snap();
    exp_t e;
    e.g = m_g; e.l = m_locked; e.e = m_err; e.b = (m_phase != 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: every sampled pd_valid strobe has exactly one expected response queued.
  always @(posedge clk) begin
    if (pd_valid && rst_n) begin
      exp_t e;
      #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pd_resp: strobe with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (gamma !== e.g[DB-1:0] || locked !== e.l[0] || err_sat !== e.e[0] || busy !== e.b[0]) begin
          n_fail++;
          $display("FAIL pd_resp: got g=%0d l=%0b e=%0b b=%0b expected g=%0d l=%0d e=%0d b=%0d at %0t",
                   gamma, locked, err_sat, busy, e.g, e.l, e.e, e.b, $time);
        end
      end
    end
  end

  // Stray strobe inside a settle window (or in IDLE): must change nothing.
  task automatic junk();
    pd_valid = 1'b1;
    pd_late  = 1'($urandom_range(0, 1));
    sb.push_back(model_snap());
    @(negedge clk);
    pd_valid = 1'b0;
    pd_late  = 1'b0;
  endtask

  task automatic decide(input bit late);
    bit settle;
    int n;
    repeat (SC + 4 + $urandom_range(0, 3)) @(negedge clk);
    pd_valid = 1'b1;
    pd_late  = late;
    settle   = model_decide(late);
    sb.push_back(model_snap());
    @(negedge clk);
    pd_valid = 1'b0;
    pd_late  = 1'b0;
    if (settle) begin
      n = $urandom_range(0, 2);
      repeat (n) junk();
    end
  endtask

  // Closed-loop PD: asks for more delay while the applied tap is at or below the target.
  task automatic pd_to(input int target, input int count, input int noise_pct);
    bit late;
    for (int i = 0; i < count; i++) begin
      late = (int'(gamma) <= target);
      if ($urandom_range(0, 99) < noise_pct) late = ~late;
      decide(late);
    end
  endtask

  task automatic forced(input bit late, input int count);
    for (int i = 0; i < count; i++) decide(late);
  endtask

  task automatic do_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    model_start();
    @(negedge clk);
    start = 1'b0;
    check("start_gamma", gamma, GMID);
    check("start_busy", busy, 1);
    check("start_flags", {locked, err_sat}, 0);
    repeat ($urandom_range(0, 2)) junk();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    model_reset();
    #12;
    check("rst_gamma", gamma, GMID);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // strobe in IDLE is ignored
    junk();

    // target 21
    do_start();
    pd_to(21, DB, 0);
    check("t1_gamma", gamma, 21);
    check("t1_busy", busy, 1);
    pd_to(21, 9, 0);

    // target 31: saturation high
    do_start();
    pd_to(31, DB, 0);
    check("t2_sar", gamma, 31);
    forced(1'b1, 7);
    check("t2_gamma", gamma, 31);
    check("t2_err", err_sat, 1);

    // target 0: saturation low
    do_start();
    pd_to(0, DB, 0);
    check("t3_sar", gamma, 0);
    forced(1'b0, 7);
    check("t3_gamma", gamma, 0);
    check("t3_err", err_sat, 1);

    // dither 12/13 -> lock, then two same-direction steps drop it
    do_start();
    pd_to(12, DB, 0);
    check("t4_sar", gamma, 12);
    pd_to(12, 15, 0);
    check("t4_lock", locked, 1);
    check("t4_lock_g", gamma, 13);
    forced(1'b1, 6);
    check("t4_unlock", locked, 0);
    check("t4_unlock_g", gamma, 15);

    // random targets with noisy PD
    for (int r = 0; r < 4; r++) begin
      tgt = $urandom_range(0, GMAX);
      do_start();
      pd_to(tgt, DB, 0);
      check("rnd_sar", gamma, tgt);
      pd_to(tgt, 24, 15);
      check("rnd_trk", gamma, m_g);
      check("rnd_flags", {locked, err_sat}, {m_locked[0], m_err[0]});
    end

    // stop + start together mid-SAR: stop wins, gamma held
    do_start();
    pd_to(7, 2, 0);
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b1;
    m_phase = 0;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    check("t6_idle", busy, 0);
    check("t6_hold", gamma, m_g);
    junk();
    check("t6_hold2", gamma, m_g);

    // async reset mid-tracking with err_sat set
    do_start();
    pd_to(31, DB, 0);
    forced(1'b1, 4);
    check("t6_err_pre", err_sat, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_gamma", gamma, GMID);
    check("arst_busy", busy, 0);
    check("arst_flags", {locked, err_sat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
